// File: rtl/chess_turn_clock.sv
// rtl/chess_turn_clock.sv - two-player chess clock with turn switching, Fischer increment and flag fall
//
// Ports:
//   clk            system clock
//   reset_n        asynchronous active-low reset
//   load           pulse: preset both clocks from mode_sel, go to READY
//   mode_sel[1:0]  time control: 0=6000, 1=18000, 2=60000, 3=180000 centiseconds
//   start          pulse: begin play with white to move
//   pause          level: freeze the running clock while high
//   move_done      pulse: side to move completed a legal move
//   white_cs[17:0] white remaining centiseconds
//   black_cs[17:0] black remaining centiseconds
//   active_player  0 = white to move, 1 = black to move
//   running        high while in RUN
//   time_up_white  sticky: white flag fell
//   time_up_black  sticky: black flag fell
//   game_over      high while in OVER
module chess_turn_clock #(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int TICK_HZ     = 100,
    parameter int INC_CS      = 0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        load,
    input  logic [1:0]  mode_sel,
    input  logic        start,
    input  logic        pause,
    input  logic        move_done,
    output logic [17:0] white_cs,
    output logic [17:0] black_cs,
    output logic        active_player,
    output logic        running,
    output logic        time_up_white,
    output logic        time_up_black,
    output logic        game_over
);

    localparam int DIV = CLK_FREQ_HZ / TICK_HZ;
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [18:0]   INC19    = 19'(INC_CS);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_READY  = 3'd1,
        S_RUN    = 3'd2,
        S_PAUSED = 3'd3,
        S_OVER   = 3'd4
    } state_t;

    state_t         state, state_n;
    logic [DW-1:0]  div_q, div_n;
    logic [17:0]    white_n, black_n;
    logic           ap_n, tuw_n, tub_n;

    logic           tick;
    logic [17:0]    active_cs;
    logic [17:0]    after_tick;
    logic [18:0]    inc_sum;
    logic [17:0]    inc_sat;

    function automatic logic [17:0] preset(input logic [1:0] m);
        case (m)
            2'd0:    preset = 18'd6000;
            2'd1:    preset = 18'd18000;
            2'd2:    preset = 18'd60000;
            default: preset = 18'd180000;
        endcase
    endfunction

    // Datapath helpers for the side to move. The decrement is taken before
    // the increment so a move landing on a tick nets clock - 1 + INC.
    always_comb begin
        tick       = (state == S_RUN) && (div_q == DIV_LAST);
        active_cs  = active_player ? black_cs : white_cs;
        after_tick = (tick && (active_cs != 18'd0)) ? active_cs - 18'd1 : active_cs;
        inc_sum    = {1'b0, after_tick} + INC19;
        inc_sat    = inc_sum[18] ? 18'h3FFFF : inc_sum[17:0];
    end

    always_comb begin
        state_n = state;
        div_n   = div_q;
        white_n = white_cs;
        black_n = black_cs;
        ap_n    = active_player;
        tuw_n   = time_up_white;
        tub_n   = time_up_black;

        if (load) begin
            state_n = S_READY;
            div_n   = '0;
            white_n = preset(mode_sel);
            black_n = preset(mode_sel);
            ap_n    = 1'b0;
            tuw_n   = 1'b0;
            tub_n   = 1'b0;
        end else begin
            case (state)
                S_READY: begin
                    if (start) state_n = pause ? S_PAUSED : S_RUN;
                end
                S_RUN: begin
                    div_n = tick ? '0 : div_q + DW'(1);
                    if (active_player) black_n = after_tick;
                    else               white_n = after_tick;

                    if (tick && (active_cs == 18'd1)) begin
                        // Flag fall beats any coincident move.
                        state_n = S_OVER;
                        if (active_player) tub_n = 1'b1;
                        else               tuw_n = 1'b1;
                    end else begin
                        if (move_done) begin
                            ap_n  = ~active_player;
                            div_n = '0;
                            if (active_player) black_n = inc_sat;
                            else               white_n = inc_sat;
                        end
                        if (pause) state_n = S_PAUSED;
                    end
                end
                S_PAUSED: begin
                    if (!pause) state_n = S_RUN;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= S_IDLE;
            div_q         <= '0;
            white_cs      <= '0;
            black_cs      <= '0;
            active_player <= 1'b0;
            time_up_white <= 1'b0;
            time_up_black <= 1'b0;
            running       <= 1'b0;
            game_over     <= 1'b0;
        end else begin
            state         <= state_n;
            div_q         <= div_n;
            white_cs      <= white_n;
            black_cs      <= black_n;
            active_player <= ap_n;
            time_up_white <= tuw_n;
            time_up_black <= tub_n;
            running       <= (state_n == S_RUN);
            game_over     <= (state_n == S_OVER);
        end
    end

endmodule

// File: tb/tb_chess_turn_clock.sv
// tb/tb_chess_turn_clock.sv - table-driven checks for chess_turn_clock
module tb_chess_turn_clock;

    logic        clk;
    logic        reset_n;
    logic        load;
    logic [1:0]  mode_sel;
    logic        start;
    logic        pause;
    logic        move_done;
    logic [17:0] white_cs;
    logic [17:0] black_cs;
    logic        active_player;
    logic        running;
    logic        time_up_white;
    logic        time_up_black;
    logic        game_over;

    int checks;
    int failures;

    chess_turn_clock #(
        .CLK_FREQ_HZ (1000),
        .TICK_HZ     (100),
        .INC_CS      (200)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .load          (load),
        .mode_sel      (mode_sel),
        .start         (start),
        .pause         (pause),
        .move_done     (move_done),
        .white_cs      (white_cs),
        .black_cs      (black_cs),
        .active_player (active_player),
        .running       (running),
        .time_up_white (time_up_white),
        .time_up_black (time_up_black),
        .game_over     (game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        ld;
        logic [1:0]  mode;
        logic        st;
        logic        pz;
        logic        mv;
        int          idle;
        logic [17:0] ew;
        logic [17:0] eb;
        logic        eap;
        logic        erun;
        logic        etuw;
        logic        etub;
        logic        ego;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string name, input logic ld, input logic [1:0] mode,
                       input logic st, input logic pz, input logic mv, input int idle,
                       input logic [17:0] ew, input logic [17:0] eb, input logic eap,
                       input logic erun, input logic etuw, input logic etub, input logic ego);
        vec_t v;
        v.name = name; v.ld = ld; v.mode = mode; v.st = st; v.pz = pz; v.mv = mv;
        v.idle = idle; v.ew = ew; v.eb = eb; v.eap = eap; v.erun = erun;
        v.etuw = etuw; v.etub = etub; v.ego = ego;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [17:0] act, input logic [17:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string name, input logic [17:0] ew, input logic [17:0] eb,
                           input logic eap, input logic erun, input logic etuw,
                           input logic etub, input logic ego);
        chk({name, ".white_cs"},      white_cs,             ew);
        chk({name, ".black_cs"},      black_cs,             eb);
        chk({name, ".active_player"}, 18'(active_player),   18'(eap));
        chk({name, ".running"},       18'(running),         18'(erun));
        chk({name, ".time_up_white"}, 18'(time_up_white),   18'(etuw));
        chk({name, ".time_up_black"}, 18'(time_up_black),   18'(etub));
        chk({name, ".game_over"},     18'(game_over),       18'(ego));
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        reset_n   = 1'b0;
        load      = 1'b0;
        mode_sel  = 2'd0;
        start     = 1'b0;
        pause     = 1'b0;
        move_done = 1'b0;

        //   name            ld mode st pz mv idle    white   black   ap run tuw tub go
        add("reset",         0, 0,   0, 0, 0, 0,     0,      0,      0, 0,  0,  0,  0);
        add("load_m1",       1, 1,   0, 0, 0, 0,     18000,  18000,  0, 0,  0,  0,  0);
        add("load_m0",       1, 0,   0, 0, 0, 0,     6000,   6000,   0, 0,  0,  0,  0);
        add("run100",        0, 0,   1, 0, 0, 100,   5990,   6000,   0, 1,  0,  0,  0);
        add("move_inc",      0, 0,   0, 0, 1, 0,     6190,   6000,   1, 1,  0,  0,  0);
        add("black_tick",    0, 0,   0, 0, 0, 9,     6190,   5999,   1, 1,  0,  0,  0);
        add("to_phase9",     0, 0,   0, 0, 0, 8,     6190,   5999,   1, 1,  0,  0,  0);
        add("move_on_tick",  0, 0,   0, 0, 1, 0,     6190,   6198,   0, 1,  0,  0,  0);
        add("phase3",        0, 0,   0, 0, 0, 2,     6190,   6198,   0, 1,  0,  0,  0);
        add("pause500",      0, 0,   0, 1, 0, 500,   6190,   6198,   0, 0,  0,  0,  0);
        add("move_paused",   0, 0,   0, 1, 1, 0,     6190,   6198,   0, 0,  0,  0,  0);
        add("resume",        0, 0,   0, 0, 0, 5,     6190,   6198,   0, 1,  0,  0,  0);
        add("resume_tick",   0, 0,   0, 0, 0, 0,     6189,   6198,   0, 1,  0,  0,  0);
        add("load_m0_b",     1, 0,   0, 0, 0, 0,     6000,   6000,   0, 0,  0,  0,  0);
        add("run_to_1",      0, 0,   1, 0, 0, 59990, 1,      6000,   0, 1,  0,  0,  0);
        add("to_last_phase", 0, 0,   0, 0, 0, 8,     1,      6000,   0, 1,  0,  0,  0);
        add("flag_fall",     0, 0,   0, 0, 1, 0,     0,      6000,   0, 0,  1,  0,  1);
        add("over_hold",     0, 0,   1, 0, 1, 50,    0,      6000,   0, 0,  1,  0,  1);
        add("load_clears",   1, 2,   0, 0, 0, 0,     60000,  60000,  0, 0,  0,  0,  0);
        add("start_paused",  0, 0,   1, 1, 0, 0,     60000,  60000,  0, 0,  0,  0,  0);
        add("unpause",       0, 0,   0, 0, 0, 0,     60000,  60000,  0, 1,  0,  0,  0);

        edges(3);
        reset_n = 1'b1;
        edges(1);

        foreach (vecs[i]) begin
            load      = vecs[i].ld;
            mode_sel  = vecs[i].mode;
            start     = vecs[i].st;
            pause     = vecs[i].pz;
            move_done = vecs[i].mv;
            edges(1);
            load      = 1'b0;
            start     = 1'b0;
            move_done = 1'b0;
            edges(vecs[i].idle);
            chk_all(vecs[i].name, vecs[i].ew, vecs[i].eb, vecs[i].eap,
                    vecs[i].erun, vecs[i].etuw, vecs[i].etub, vecs[i].ego);
        end

        // Asynchronous reset mid-RUN: outputs clear before the next edge.
        edges(20);
        #2;
        reset_n = 1'b0;
        #1;
        chk_all("async_reset", 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        reset_n = 1'b1;
        edges(1);

        // start from IDLE is ignored until a load arrives.
        start = 1'b1;
        edges(1);
        start = 1'b0;
        edges(20);
        chk_all("start_in_idle", 0, 0, 0, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/chess_turn_clock.md
Name: chess_turn_clock

Overview:
- Two-player chess clock controller that sits upstream of the per-player MM:SS:mm display counters and the game-over logic.
- Holds white and black remaining time in centiseconds and runs only the side to move.
- Switches turns on move_done pulses from move validation, applies an optional per-move increment, and flags which player's flag fell.
- Its centisecond outputs feed the display formatting stage directly.

Parameters:
- CLK_FREQ_HZ, 50_000_000: clk frequency in Hz.
- TICK_HZ, 100: countdown tick rate (centiseconds). DIV = CLK_FREQ_HZ/TICK_HZ, must be >= 2.
- INC_CS, 0: centiseconds added to the mover's clock on each accepted move (Fischer increment).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset_n, asynchronous, active-low.
- load  in  1  single-cycle pulse: preset both clocks from mode_sel.
- mode_sel  in  2  time control: 0=6000, 1=18000, 2=60000, 3=180000 cs.
- start  in  1  single-cycle pulse: begin play (white to move).
- pause  in  1  level: freeze the running clock while high.
- move_done  in  1  single-cycle pulse: active player completed a legal move.
- white_cs  out  18  white remaining centiseconds.
- black_cs  out  18  black remaining centiseconds.
- active_player  out  1  0 = white to move, 1 = black to move.
- running  out  1  high while in RUN.
- time_up_white  out  1  sticky: white clock reached 0.
- time_up_black  out  1  sticky: black clock reached 0.
- game_over  out  1  high while in OVER.

Behaviour:
- All outputs are registered. Reset values: white_cs=0, black_cs=0, active_player=0, both time_up flags 0, running=0, game_over=0, divider=0, state=IDLE.
- States: IDLE, READY, RUN, PAUSED, OVER. running = (state==RUN). game_over = (state==OVER).
- load in any state (highest priority after reset): both clocks <= preset(mode_sel), active_player<=0, divider<=0, time_up flags cleared, next state READY. load takes priority over start, move_done and tick in the same cycle.
- IDLE: ignores start, pause and move_done.
- READY: start -> RUN on the next cycle. If pause is high in the start cycle, go to PAUSED instead. move_done ignored.
- RUN, divider:
  - divider increments every cycle.
  - When divider==DIV-1: divider<=0 and a tick occurs. A tick decrements the active player's clock by 1 only when that clock is > 0.
  - The first tick after start lands DIV cycles after RUN is entered.
- RUN, timeout: a tick that takes the active clock from 1 to 0 sets that player's time_up flag and moves to OVER on the same edge. Outputs show 0 in the following cycle.
- RUN, move_done:
  - active_player toggles, divider<=0.
  - Mover's clock <= min(clock + INC_CS, 2^18-1), saturating.
  - If a tick coincides with move_done, the decrement is applied first. If that decrement reaches 0, the timeout wins and the move is ignored (no toggle, no increment). Otherwise the result is clock - 1 + INC_CS.
- RUN, pause: pause high -> PAUSED next cycle. A tick in that same cycle is still applied.
- PAUSED:
  - divider and clocks hold.
  - move_done and start are ignored.
  - pause low -> RUN; the divider resumes from its held value.
- OVER: all registers hold. Only load or reset leaves this state.
- Width rules: clock arithmetic is 19-bit internally before saturation. Divider width is clog2(DIV).
- Reset asserted mid-game returns to the reset values immediately (asynchronous).

Test Plan:
- Bench uses CLK_FREQ_HZ=1000, TICK_HZ=100, so DIV=10.
- Reset, then load with mode_sel=1 -> white_cs=black_cs=18000, active_player=0, state READY, running=0.
- Load mode_sel=0, start, run 100 cycles -> white_cs=5990, black_cs=6000. Then move_done -> active_player=1, divider restarts, and 10 cycles later black_cs=5999.
- INC_CS=200: move_done with white_cs=5990 and no tick that cycle -> white_cs=6190, then black counts down. Tick coincident with move_done -> white_cs=6189.
- Pause high for 500 cycles mid-RUN -> both clocks unchanged and move_done ignored. Deassert pause -> countdown resumes at the held divider phase.
- Force white_cs to 1 (load mode 0, run 5999 ticks) -> next tick gives white_cs=0, time_up_white=1, game_over=1. A move_done in the final tick cycle is ignored. Further cycles: no change until load, which clears the flag and returns to READY.
- Assert reset_n low while in RUN -> all outputs 0 and state IDLE asynchronously. A start issued afterwards is ignored until load.
